// File: rtl/ddr_pkg.sv
// ddr_pkg: shared types and constants for the note sequencer and its pattern ROM
package ddr_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, PLAY, PAUSED, DONE} state_t;
  localparam int LANES = 4;
  localparam logic [1:0] TEMPO_1X  = 2'd0;
  localparam logic [1:0] TEMPO_3_4 = 2'd1;
  localparam logic [1:0] TEMPO_1_2 = 2'd2;
  localparam logic [1:0] TEMPO_1_4 = 2'd3;
  function automatic int beat_period(int t, int sel);
    return t - (t / 4) * sel;
  endfunction
endpackage

// File: rtl/pattern_rom.sv
// pattern_rom: combinational song table, one 4-bit lane mask per step
// ports: addr step index in; mask lane mask out (0 = rest, 0 beyond the song end)
module pattern_rom
  import ddr_pkg::*;
#(
  parameter int STEP_W      = 5,
  parameter int PATTERN_LEN = 32,
  parameter bit TEST_SONG   = 1'b0
) (
  input  logic [STEP_W-1:0] addr,
  output logic [LANES-1:0]  mask
);
  always_comb begin
    mask = '0;
    if (int'(addr) < PATTERN_LEN) begin
      if (TEST_SONG)
        case (int'(addr))
          0:       mask = 4'b0001;
          1:       mask = 4'b0110;
          2:       mask = 4'b0000;
          3:       mask = 4'b1000;
          default: mask = '0;
        endcase
      else
        case (int'(addr))
          0:       mask = 4'b0001;
          1:       mask = 4'b0010;
          2:       mask = 4'b0100;
          3:       mask = 4'b1000;
          4:       mask = 4'b0001;
          5:       mask = 4'b0000;
          6:       mask = 4'b0011;
          7:       mask = 4'b0000;
          8:       mask = 4'b1000;
          9:       mask = 4'b0100;
          10:      mask = 4'b0010;
          11:      mask = 4'b0001;
          12:      mask = 4'b1001;
          13:      mask = 4'b0000;
          14:      mask = 4'b0110;
          15:      mask = 4'b0000;
          16:      mask = 4'b0001;
          17:      mask = 4'b0001;
          18:      mask = 4'b0010;
          19:      mask = 4'b0010;
          20:      mask = 4'b0100;
          21:      mask = 4'b0100;
          22:      mask = 4'b1000;
          23:      mask = 4'b0000;
          24:      mask = 4'b0101;
          25:      mask = 4'b1010;
          26:      mask = 4'b0101;
          27:      mask = 4'b1010;
          28:      mask = 4'b0000;
          29:      mask = 4'b1100;
          30:      mask = 4'b0011;
          31:      mask = 4'b1111;
          default: mask = '0;
        endcase
    end
  end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays a fixed 4-lane note pattern at a selectable tempo after a count-in
// ports: clk, reset (sync, active-high); start (rising edge starts a song), pause (level),
//   tempo_sel (beat period select, sampled on start); lane_en (one-cycle lane pulses),
//   score_clr (one-cycle pulse at song start), lead_count (count-in beats left),
//   step_idx (next step to play), busy (song in progress), song_done (last step played)
module note_sequencer
  import ddr_pkg::*;
#(
  parameter int TICKS_PER_BEAT = 25000000,
  parameter int PATTERN_LEN    = 32,
  parameter int STEP_W         = 5,
  parameter int LEAD_BEATS     = 4,
  parameter bit TEST_SONG      = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic [1:0]        tempo_sel,
  output logic [LANES-1:0]  lane_en,
  output logic              score_clr,
  output logic [2:0]        lead_count,
  output logic [STEP_W-1:0] step_idx,
  output logic              busy,
  output logic              song_done
);
  localparam int CNT_W = $clog2(TICKS_PER_BEAT);
  localparam logic [CNT_W-1:0] PM1_1X  = CNT_W'(beat_period(TICKS_PER_BEAT, int'(TEMPO_1X)) - 1);
  localparam logic [CNT_W-1:0] PM1_3_4 = CNT_W'(beat_period(TICKS_PER_BEAT, int'(TEMPO_3_4)) - 1);
  localparam logic [CNT_W-1:0] PM1_1_2 = CNT_W'(beat_period(TICKS_PER_BEAT, int'(TEMPO_1_2)) - 1);
  localparam logic [CNT_W-1:0] PM1_1_4 = CNT_W'(beat_period(TICKS_PER_BEAT, int'(TEMPO_1_4)) - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PATTERN_LEN - 1);
  localparam logic [2:0] INIT_LEAD = 3'(LEAD_BEATS);
  state_t state, state_n, run;
  logic resume_play, resume_play_n, start_q, go, frozen, tick;
  logic [CNT_W-1:0] cnt, cnt_n, pm1, pm1_n, pm1_sel;
  logic [STEP_W-1:0] step_n;
  logic [2:0] lead_n;
  logic [LANES-1:0] mask, lane_n;
  logic clr_n, done_n;
  pattern_rom #(.STEP_W(STEP_W), .PATTERN_LEN(PATTERN_LEN), .TEST_SONG(TEST_SONG)) u_rom (
    .addr(step_idx),
    .mask(mask)
  );
  // period is stored as P-1 so the full T fits the counter width
  assign pm1_sel = tempo_sel == TEMPO_1X  ? PM1_1X  :
                   tempo_sel == TEMPO_3_4 ? PM1_3_4 :
                   tempo_sel == TEMPO_1_2 ? PM1_1_2 : PM1_1_4;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      resume_play <= 1'b0;
      start_q     <= 1'b0;
      cnt         <= '0;
      pm1         <= '0;
      step_idx    <= '0;
      lead_count  <= '0;
      lane_en     <= '0;
      score_clr   <= 1'b0;
      song_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      resume_play <= resume_play_n;
      start_q     <= start;
      cnt         <= cnt_n;
      pm1         <= pm1_n;
      step_idx    <= step_n;
      lead_count  <= lead_n;
      lane_en     <= lane_n;
      score_clr   <= clr_n;
      song_done   <= done_n;
      busy        <= state == LEAD || state == PLAY || state == PAUSED;
    end
  end
  // a released PAUSED cycle behaves as the saved state so counting resumes without a lost cycle
  always_comb begin
    go            = start & ~start_q;
    run           = state == PAUSED ? (resume_play ? PLAY : LEAD) : state;
    frozen        = pause && (run == LEAD || run == PLAY);
    tick          = cnt == pm1;
    state_n       = state;
    resume_play_n = resume_play;
    cnt_n         = cnt;
    pm1_n         = pm1;
    step_n        = step_idx;
    lead_n        = lead_count;
    lane_n        = '0;
    clr_n         = 1'b0;
    done_n        = 1'b0;
    if (frozen) begin
      state_n       = PAUSED;
      resume_play_n = run == PLAY;
    end else if (run == IDLE || run == DONE) begin
      if (go) begin
        // the go cycle is beat count 0, so the counter leaves it at 1 (mod P)
        clr_n   = 1'b1;
        pm1_n   = pm1_sel;
        cnt_n   = pm1_sel == '0 ? '0 : CNT_W'(1);
        step_n  = '0;
        lead_n  = INIT_LEAD;
        state_n = LEAD_BEATS == 0 ? PLAY : LEAD;
      end
    end else begin
      state_n = run;
      cnt_n   = tick ? '0 : cnt + 1'b1;
      if (tick && run == LEAD) begin
        lead_n  = lead_count - 1'b1;
        state_n = lead_count == 3'd1 ? PLAY : LEAD;
      end
      if (tick && run == PLAY) begin
        lane_n = mask;
        if (step_idx == LAST_STEP) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else
          step_n = step_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench for note_sequencer against a beat-arithmetic song model
module tb_note_sequencer;
  localparam int T = 8;
  localparam int LEAD = 2;
  localparam int LEN = 4;
  typedef struct {
    int cyc;
    logic [3:0] lane;
    logic clr;
    logic done;
  } ev_t;
  logic clk, reset, start, pause;
  logic [1:0] tempo_sel;
  logic [3:0] lane_en;
  logic score_clr, busy, song_done;
  logic [2:0] lead_count;
  logic [4:0] step_idx;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit pause_sched [0:8191];
  logic [3:0] song [0:LEN-1] = '{4'b0001, 4'b0110, 4'b0000, 4'b1000};
  ev_t exp_q [$];
  note_sequencer #(
    .TICKS_PER_BEAT(T), .PATTERN_LEN(LEN), .STEP_W(5), .LEAD_BEATS(LEAD), .TEST_SONG(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .tempo_sel(tempo_sel),
    .lane_en(lane_en), .score_clr(score_clr), .lead_count(lead_count),
    .step_idx(step_idx), .busy(busy), .song_done(song_done)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1 pause = cyc < 8192 ? pause_sched[cyc] : 1'b0;
  end
  always @(negedge clk) begin
    ev_t e;
    if (lane_en != 0 || score_clr || song_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL event cyc=%0d got lane=%b clr=%b done=%b, expected no event", cyc, lane_en, score_clr, song_done);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.lane != lane_en || e.clr != score_clr || e.done != song_done) begin
          failures++;
          $display("FAIL event cyc=%0d got lane=%b clr=%b done=%b, expected cyc=%0d lane=%b clr=%b done=%b",
                   cyc, lane_en, score_clr, song_done, e.cyc, e.lane, e.clr, e.done);
        end
      end
    end
  end
  task automatic goto(int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic chk(string name, int act, int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, want);
    end
  endtask
  // Beat n ends in the cycle where the n*P-th unpaused cycle (go cycle included) falls;
  // steps play on beats LEAD+1.., and each registered event appears the cycle after.
  task automatic model_song(input int g, input int p, output int d);
    int c, act, tk, st;
    c = g;
    act = 0;
    tk = g;
    exp_q.push_back('{g + 1, 4'b0000, 1'b1, 1'b0});
    for (int n = 1; n <= LEAD + LEN; n++) begin
      while (act < n * p) begin
        if (c == g || !pause_sched[c]) act++;
        c++;
      end
      tk = c - 1;
      if (n > LEAD) begin
        st = n - LEAD - 1;
        if (song[st] != 0 || st == LEN - 1) exp_q.push_back('{tk + 1, song[st], 1'b0, st == LEN - 1});
      end
    end
    d = tk + 1;
  endtask
  initial begin
    int d, cur, g, p, sel, nw, s, len;
    reset = 1;
    start = 0;
    pause = 0;
    tempo_sel = 0;
    goto(3);
    reset = 0;
    chk("reset_lane", lane_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_step", step_idx, 0);
    chk("reset_lead", lead_count, 0);
    chk("reset_clr", score_clr, 0);
    model_song(10, 8, d);
    goto(10); start = 1;
    goto(11); chk("lead_at_go", lead_count, 2);
    goto(15); start = 0;
    goto(20); chk("lead_after_beat1", lead_count, 1);
    goto(28); chk("lead_in_play", lead_count, 0);
    goto(58); chk("busy_at_done", busy, 1);
    goto(59); chk("busy_after_done", busy, 0);
    chk("step_hold_done", step_idx, LEN - 1);
    chk("basic_done_cycle", d, 58);
    model_song(70, 4, d);
    goto(70); start = 1; tempo_sel = 2;
    goto(72); start = 0;
    goto(75); tempo_sel = 0;
    goto(83); start = 1;
    goto(84); tempo_sel = 3;
    goto(88); start = 0;
    goto(d + 1); chk("tempo_busy_end", busy, 0);
    for (int i = 128; i <= 132; i++) pause_sched[i] = 1;
    pause_sched[152] = 1;
    model_song(100, 8, d);
    goto(100); start = 1; tempo_sel = 0;
    goto(103); start = 0;
    goto(128); chk("pause_step_a", step_idx, 1);
    goto(132); chk("pause_step_b", step_idx, 1);
    chk("pause_busy", busy, 1);
    goto(d + 1); chk("pause_busy_end", busy, 0);
    model_song(170, 8, d);
    goto(170); start = 1;
    goto(230); chk("held_start_idle", busy, 0);
    goto(240); start = 0;
    model_song(245, 8, d);
    goto(245); start = 1;
    goto(278); start = 0;
    chk("step_before_reset", step_idx, 2);
    goto(280); reset = 1;
    while (exp_q.size() > 0 && exp_q[$].cyc > 280) void'(exp_q.pop_back());
    goto(281); reset = 0;
    chk("midreset_busy", busy, 0);
    chk("midreset_step", step_idx, 0);
    chk("midreset_lane", lane_en, 0);
    chk("midreset_lead", lead_count, 0);
    model_song(300, 8, d);
    goto(300); start = 1;
    goto(301); chk("replay_lead", lead_count, 2);
    goto(303); start = 0;
    goto(d + 1); chk("replay_step", step_idx, LEN - 1);
    cur = d + 1;
    for (int k = 0; k < 8; k++) begin
      g = cur + $urandom_range(3, 15);
      sel = $urandom_range(0, 3);
      p = T - (T / 4) * sel;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        s = $urandom_range(g + 1, g + (LEAD + LEN) * p - 1);
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) pause_sched[s + i] = 1;
      end
      model_song(g, p, d);
      goto(g); start = 1; tempo_sel = 2'(sel);
      goto(g + 1); start = 0; tempo_sel = 2'($urandom_range(0, 3));
      goto(d); chk("rand_busy_last", busy, 1);
      goto(d + 1); chk("rand_busy_end", busy, 0);
      chk("rand_step_end", step_idx, LEN - 1);
      cur = d + 1;
    end
    goto(cur + 20);
    chk("missing_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
